// File: rtl/sequenciador_deslocamento_pkg.sv
// rtl/sequenciador_deslocamento_pkg.sv - shared widths and FSM state type for the shift sequencer
package sequenciador_deslocamento_pkg;

    localparam int NBITS_DATA  = 4;
    localparam int NBITS_SHIFT = 1;
    localparam int NBITS_COUNT = $clog2(NBITS_DATA + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sequenciador_deslocamento_contador.sv
// rtl/sequenciador_deslocamento_contador.sv - contador_passos: loadable down-counter with zero/one detect
module contador_passos #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero,
    output logic             one
);

    logic [WIDTH-1:0] rem;

    // load wins over dec; the counter never wraps below zero
    always_ff @(posedge clk) begin
        if (reset) begin
            rem <= '0;
        end else if (load) begin
            rem <= load_value;
        end else if (dec && (rem != '0)) begin
            rem <= rem - 1'b1;
        end
    end

    assign zero = (rem == '0);
    assign one  = (rem == WIDTH'(1));

endmodule

// File: rtl/sequenciador_deslocamento.sv
// rtl/sequenciador_deslocamento.sv - left-shift sequencer driving an external shift register; SEQ_OVERFLOW_EN enables the sticky ovf flag
module sequenciador_deslocamento
    import sequenciador_deslocamento_pkg::*;
#(
    parameter int NBITS_DATA  = sequenciador_deslocamento_pkg::NBITS_DATA,
    parameter int NBITS_SHIFT = sequenciador_deslocamento_pkg::NBITS_SHIFT,
    parameter int NBITS_COUNT = $clog2(NBITS_DATA + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic signed [NBITS_DATA-1:0]  value,
    input  logic        [NBITS_COUNT-1:0] count,
    input  logic signed [NBITS_DATA-1:0]  reg_q,
    output logic signed [NBITS_DATA-1:0]  data_in,
    output logic        [NBITS_SHIFT-1:0] shift,
    output logic signed [NBITS_DATA-1:0]  result,
    output logic                          busy,
    output logic                          done,
    output logic                          ovf
);

    localparam logic [NBITS_COUNT-1:0] MAX_COUNT = NBITS_COUNT'(NBITS_DATA);

    state_t                         state;
    state_t                         next_state;
    logic signed [NBITS_DATA-1:0]   value_q;
    logic        [NBITS_COUNT-1:0]  count_sat;
    logic                           accept;
    logic                           rem_zero;
    logic                           rem_one;

    assign accept    = (state == ST_IDLE) && start;
    assign count_sat = (count > MAX_COUNT) ? MAX_COUNT : count;

    contador_passos #(
        .WIDTH (NBITS_COUNT)
    ) u_contador (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .dec        (state == ST_SHIFT),
        .load_value (count_sat),
        .zero       (rem_zero),
        .one        (rem_one)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            value_q <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                value_q <= value;
            end
        end
    end

    always_comb begin
        next_state = state;
        data_in    = reg_q;
        shift      = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                data_in    = value_q;
                busy       = 1'b1;
                next_state = rem_zero ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                shift = NBITS_SHIFT'(1);
                busy  = 1'b1;
                if (rem_one) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign result = reg_q;

`ifdef SEQ_OVERFLOW_EN
    logic ovf_q;

    // sign change between the top two bits means the next shift overflows
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if ((state == ST_SHIFT) &&
                     (reg_q[NBITS_DATA-1] != reg_q[NBITS_DATA-2])) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sequenciador_deslocamento.sv
// tb/tb_sequenciador_deslocamento.sv - bench: sequencer looped with a shift register, checked against a reference model
module tb_sequenciador_deslocamento;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic signed [3:0] value;
    logic        [2:0] count;
    logic signed [3:0] reg_q;
    logic signed [3:0] data_in;
    logic        [0:0] shift;
    logic signed [3:0] result;
    logic              busy;
    logic              done;
    logic              ovf;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sequenciador_deslocamento dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .value   (value),
        .count   (count),
        .reg_q   (reg_q),
        .data_in (data_in),
        .shift   (shift),
        .result  (result),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    // downstream shift register sharing the reset line
    always @(posedge clk) begin
        if (reset) reg_q <= '0;
        else       reg_q <= data_in << shift;
    end

    function automatic logic [3:0] shl(input logic [3:0] v, input int k);
        if (k >= N) return 4'b0000;
        return v << k;
    endfunction

    // true if any of the first j shift steps starts from a value whose top two bits differ
    function automatic logic flag_upto(input logic [3:0] v, input int j);
        logic [3:0] x;
        for (int i = 0; i < j; i++) begin
            x = shl(v, i);
            if (x[3] != x[2]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk1(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // reference model: phase -1 is idle, 0 the load cycle, 1..sat shifting, sat+1 done
    int         phase = -1;
    logic [3:0] m_v = '0;
    int         m_sat = 0;
    logic [3:0] hold_reg = '0;
    logic       hold_ovf = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            phase    <= -1;
            hold_reg <= '0;
            hold_ovf <= 1'b0;
        end else if (phase == -1) begin
            if (start) begin
                phase <= 0;
                m_v   <= value;
                m_sat <= (int'(count) > N) ? N : int'(count);
            end
        end else if (phase == m_sat + 1) begin
            phase    <= -1;
            hold_reg <= shl(m_v, m_sat);
            hold_ovf <= flag_upto(m_v, m_sat);
        end else begin
            phase <= phase + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic e_busy, e_done, e_shift, e_ovf;
            e_busy  = (phase >= 0) && (phase <= m_sat);
            e_done  = (phase >= 0) && (phase == m_sat + 1);
            e_shift = (phase >= 1) && (phase <= m_sat);
`ifdef SEQ_OVERFLOW_EN
            e_ovf = (phase < 0) ? hold_ovf : flag_upto(m_v, phase - 1);
`else
            e_ovf = 1'b0;
`endif
            chk1("model_busy", int'(busy), int'(e_busy));
            chk1("model_done", int'(done), int'(e_done));
            chk1("model_shift", int'(shift), int'(e_shift));
            chk1("model_ovf", int'(ovf), int'(e_ovf));
            if (phase < 0) chk1("model_idle_result", int'(result[3:0]), int'(hold_reg));
            if (e_done) chk1("model_done_result", int'(result[3:0]), int'(shl(m_v, m_sat)));
        end
    end

    task automatic op(input logic [3:0] v, input logic [2:0] c, input logic [3:0] exp_res,
                      input int exp_lat, input int exp_shifts, input logic exp_ovf);
        int n;
        int shifts;
        @(negedge clk);
        value = v;
        count = c;
        start = 1'b1;
        n = 0;
        shifts = 0;
        do begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (shift == 1'b1) shifts++;
        end while (!done && n < 20);
        chk1("op_latency", n, exp_lat);
        chk1("op_result", int'(result[3:0]), int'(exp_res));
        chk1("op_shift_cycles", shifts, exp_shifts);
`ifdef SEQ_OVERFLOW_EN
        chk1("op_ovf", int'(ovf), int'(exp_ovf));
`else
        chk1("op_ovf", int'(ovf), 0);
`endif
    endtask

    initial begin
        int dones;
        logic [3:0] res_seen;
        reset = 1'b1;
        start = 1'b0;
        value = '0;
        count = '0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk1("reset_busy", int'(busy), 0);
        chk1("reset_done", int'(done), 0);
        chk1("reset_ovf", int'(ovf), 0);
        chk1("reset_result", int'(result[3:0]), 0);
        reset = 1'b0;

        op(4'b0011, 3'd2, 4'b1100, 4, 2, 1'b1);
        op(4'b0001, 3'd0, 4'b0001, 2, 0, 1'b0);
        op(4'b0101, 3'd7, 4'b0000, 6, 4, 1'b1);
        op(4'b0111, 3'd3, 4'b1000, 5, 3, 1'b1);
        op(4'b0001, 3'd4, 4'b0000, 6, 4, 1'b1);

        // start held high through busy and done with a different operand
        @(negedge clk);
        value = 4'b0011;
        count = 3'd2;
        start = 1'b1;
        @(negedge clk);
        value = 4'b1111;
        count = 3'd1;
        dones = 0;
        res_seen = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                res_seen = result;
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk1("busy_start_single_done", dones, 1);
        chk1("busy_start_result", int'(res_seen), 4'b1100);
        chk1("busy_start_no_queue", int'(busy), 0);

        // reset during the second shift cycle of a count=3 operation
        @(negedge clk);
        value = 4'b0011;
        count = 3'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk1("midreset_busy", int'(busy), 0);
        chk1("midreset_done", int'(done), 0);
        chk1("midreset_ovf", int'(ovf), 0);
        chk1("midreset_result", int'(result[3:0]), 0);
        reset = 1'b0;
        op(4'b0010, 3'd1, 4'b0100, 3, 1, 1'b0);

        // start coinciding with reset is dropped
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        value = 4'b1010;
        count = 3'd1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk1("start_with_reset_busy", int'(busy), 0);
        @(negedge clk);
        chk1("start_with_reset_idle", int'(busy), 0);
        chk1("start_with_reset_result", int'(result[3:0]), 0);

        op(4'b0110, 3'd1, 4'b1100, 3, 1, 1'b1);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
